// File: rtl/cond_unit_it_pkg.sv
// Shared definitions for the condition unit: ARM condition codes, flag bit
// positions inside the {Q,N,Z,C,V} register and the IT sequencer state.
package cond_pkg;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int FLAG_Q = 4;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic {
      IT_IDLE   = 1'b0,
      IT_ACTIVE = 1'b1
   } it_state_e;

endpackage

// File: rtl/cond_unit_it_if.sv
// Decode-side bundle of the condition unit: instruction control in, condition
// result, architectural flags and IT status out.
interface cond_unit_it_if #(
   parameter int IT_DEPTH = 4
) ();

   logic                InstrValid;
   logic                Stall;
   logic [3:0]          Cond;
   logic [4:0]          ALUFlags;
   logic [1:0]          FlagWrite;
   logic                Saturated;
   logic                QClear;
   logic                ITStart;
   logic [3:0]          ITFirstCond;
   logic [IT_DEPTH-1:0] ITMask;
   logic                CondEx;
   logic [4:0]          Flags;
   logic                InIT;
   logic                ITFault;

   modport master (
      output InstrValid, Stall, Cond, ALUFlags, FlagWrite, Saturated, QClear,
             ITStart, ITFirstCond, ITMask,
      input  CondEx, Flags, InIT, ITFault
   );

   modport slave (
      input  InstrValid, Stall, Cond, ALUFlags, FlagWrite, Saturated, QClear,
             ITStart, ITFirstCond, ITMask,
      output CondEx, Flags, InIT, ITFault
   );

endinterface

// File: rtl/cond_unit_it_eval.sv
// Combinational ARM condition check of a 4-bit condition against {N,Z,C,V}.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] nzcv_i,
   output logic       pass_o
);

   logic n, z, c, v;

   assign n = nzcv_i[FLAG_N];
   assign z = nzcv_i[FLAG_Z];
   assign c = nzcv_i[FLAG_C];
   assign v = nzcv_i[FLAG_V];

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      pass_o = 1'b1;
      case (cond_i)
         COND_EQ: pass_o = z;
         COND_NE: pass_o = ~z;
         COND_CS: pass_o = c;
         COND_CC: pass_o = ~c;
         COND_MI: pass_o = n;
         COND_PL: pass_o = ~n;
         COND_VS: pass_o = v;
         COND_VC: pass_o = ~v;
         COND_HI: pass_o = c & ~z;
         COND_LS: pass_o = ~c | z;
         COND_GE: pass_o = (n == v);
         COND_LT: pass_o = (n != v);
         COND_GT: pass_o = ~z & (n == v);
         COND_LE: pass_o = z | (n != v);
         default: pass_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_unit_it.sv
// Condition unit: {Q,N,Z,C,V} flag register with condition-gated writes, sticky
// saturation flag and an IT-block sequencer overriding Cond for following instructions.
module cond_unit_it
   import cond_pkg::*;
#(
   parameter int IT_DEPTH = 4,
   parameter bit STICKY_Q = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   cond_unit_it_if.slave   cu
);

   logic [4:0]          flags_q, flags_d;
   it_state_e           state_q, state_d;
   logic [3:1]          base_q, base_d;
   logic [IT_DEPTH:0]   run_q, run_d;
   logic                fault_q, fault_d;

   logic                active;
   logic                adv;
   logic                it_instr;
   logic                upd;
   logic                cond_ex;
   logic                mask_zero;
   logic                last_slot;
   logic [3:0]          eff_cond;

   assign active    = (state_q == IT_ACTIVE);
   assign eff_cond  = active ? {base_q, run_q[IT_DEPTH]} : cu.Cond;
   assign adv       = cu.InstrValid & ~cu.Stall;
   // The IT instruction that opens a block is unconditional and never writes flags.
   assign it_instr  = ~active & cu.ITStart;
   assign upd       = adv & cond_ex & ~it_instr;
   assign mask_zero = (cu.ITMask == '0);
   assign last_slot = (run_q[IT_DEPTH-2:0] == '0);

   cond_eval u_cond_eval (
      .cond_i (eff_cond),
      .nzcv_i (flags_q[3:0]),
      .pass_o (cond_ex)
   );

   always_comb begin
      flags_d = flags_q;
      if (upd & cu.FlagWrite[1]) begin
         flags_d[FLAG_N] = cu.ALUFlags[FLAG_N];
         flags_d[FLAG_Z] = cu.ALUFlags[FLAG_Z];
      end
      if (upd & cu.FlagWrite[0]) begin
         flags_d[FLAG_C] = cu.ALUFlags[FLAG_C];
         flags_d[FLAG_V] = cu.ALUFlags[FLAG_V];
      end
      if (upd & cu.Saturated) begin
         flags_d[FLAG_Q] = STICKY_Q ? 1'b1 : cu.ALUFlags[FLAG_Q];
      end else if (adv & cu.QClear) begin
         flags_d[FLAG_Q] = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      run_d   = run_q;
      fault_d = 1'b0;
      if (adv) begin
         case (state_q)
            IT_IDLE: begin
               if (cu.ITStart) begin
                  if (mask_zero) begin
                     fault_d = 1'b1;
                  end else begin
                     state_d = IT_ACTIVE;
                     base_d  = cu.ITFirstCond[3:1];
                     run_d   = {cu.ITFirstCond[0], cu.ITMask};
                  end
               end
            end
            IT_ACTIVE: begin
               // A nested IT request is refused but still consumes its block slot.
               fault_d = cu.ITStart;
               if (last_slot) begin
                  state_d = IT_IDLE;
                  base_d  = '0;
                  run_d   = '0;
               end else begin
                  run_d = {run_q[IT_DEPTH-1:0], 1'b0};
               end
            end
            default: state_d = IT_IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_q <= '0;
         state_q <= IT_IDLE;
         base_q  <= '0;
         run_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         flags_q <= flags_d;
         state_q <= state_d;
         base_q  <= base_d;
         run_q   <= run_d;
         fault_q <= fault_d;
      end
   end

   assign cu.CondEx  = cond_ex;
   assign cu.Flags   = flags_q;
   assign cu.InIT    = active;
   assign cu.ITFault = fault_q;

endmodule

// File: tb/tb_cond_unit_it.sv
// Directed vector bench for cond_unit_it: table-driven instruction stream plus a
// hand-written asynchronous reset in the middle of an IT block.
module tb_cond_unit_it;

   localparam int IT_DEPTH = 4;

   typedef struct {
      logic       valid;
      logic       stall;
      logic [3:0] cond;
      logic [4:0] alu;
      logic [1:0] fw;
      logic       sat;
      logic       qclr;
      logic       itstart;
      logic [3:0] itfc;
      logic [3:0] itmask;
      logic       e_cx;
      logic [4:0] e_flags;
      logic       e_init;
      logic       e_fault;
   } vec_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   vec_t vq[$];

   cond_unit_it_if #(.IT_DEPTH(IT_DEPTH)) cu ();

   cond_unit_it #(.IT_DEPTH(IT_DEPTH), .STICKY_Q(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .cu    (cu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic valid, input logic stall, input logic [3:0] cond,
                               input logic [4:0] alu, input logic [1:0] fw, input logic sat,
                               input logic qclr, input logic itstart, input logic [3:0] itfc,
                               input logic [3:0] itmask, input logic e_cx,
                               input logic [4:0] e_flags, input logic e_init,
                               input logic e_fault);
      vec_t t;
      t.valid = valid;     t.stall = stall;   t.cond = cond;       t.alu = alu;
      t.fw = fw;           t.sat = sat;       t.qclr = qclr;       t.itstart = itstart;
      t.itfc = itfc;       t.itmask = itmask; t.e_cx = e_cx;       t.e_flags = e_flags;
      t.e_init = e_init;   t.e_fault = e_fault;
      return t;
   endfunction

   task automatic drive(input vec_t t);
      cu.InstrValid  = t.valid;
      cu.Stall       = t.stall;
      cu.Cond        = t.cond;
      cu.ALUFlags    = t.alu;
      cu.FlagWrite   = t.fw;
      cu.Saturated   = t.sat;
      cu.QClear      = t.qclr;
      cu.ITStart     = t.itstart;
      cu.ITFirstCond = t.itfc;
      cu.ITMask      = t.itmask;
   endtask

   task automatic idle_inputs();
      drive(mk(0, 0, 4'hE, 5'b0, 2'b00, 0, 0, 0, 4'h0, 4'h0, 1, 5'b0, 0, 0));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;

      //           vl st cond alu       fw    sat qc its itfc  mask     cx flags     init flt
      // 1: ADDS then EQ / NE
      vq.push_back(mk(1, 0, 4'hE, 5'b00110, 2'b11, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b00110, 0, 0));
      vq.push_back(mk(1, 0, 4'h0, 5'b00000, 2'b00, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b00110, 0, 0));
      vq.push_back(mk(1, 0, 4'h1, 5'b00000, 2'b00, 0, 0, 0, 4'h0, 4'b0000, 0, 5'b00110, 0, 0));
      // 2: gating on a failed condition, then partial group writes
      vq.push_back(mk(1, 0, 4'hE, 5'b00010, 2'b11, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b00010, 0, 0));
      vq.push_back(mk(1, 0, 4'h0, 5'b01000, 2'b11, 0, 0, 0, 4'h0, 4'b0000, 0, 5'b00010, 0, 0));
      vq.push_back(mk(1, 0, 4'hE, 5'b01101, 2'b01, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b00001, 0, 0));
      vq.push_back(mk(1, 0, 4'hE, 5'b01110, 2'b10, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b01101, 0, 0));
      // compound conditions with N=1 Z=1 C=0 V=1
      vq.push_back(mk(1, 0, 4'hA, 5'b00000, 2'b00, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b01101, 0, 0));
      vq.push_back(mk(1, 0, 4'h8, 5'b00000, 2'b00, 0, 0, 0, 4'h0, 4'b0000, 0, 5'b01101, 0, 0));
      vq.push_back(mk(1, 0, 4'hD, 5'b00000, 2'b00, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b01101, 0, 0));
      vq.push_back(mk(1, 0, 4'hF, 5'b00000, 2'b00, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b01101, 0, 0));
      vq.push_back(mk(1, 0, 4'h4, 5'b00000, 2'b00, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b01101, 0, 0));
      // 3: sticky Q
      vq.push_back(mk(1, 0, 4'hE, 5'b00000, 2'b00, 1, 0, 0, 4'h0, 4'b0000, 1, 5'b11101, 0, 0));
      vq.push_back(mk(1, 0, 4'hE, 5'b00100, 2'b11, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b10100, 0, 0));
      vq.push_back(mk(1, 0, 4'hE, 5'b00100, 2'b11, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b10100, 0, 0));
      vq.push_back(mk(1, 0, 4'hE, 5'b00100, 2'b11, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b10100, 0, 0));
      vq.push_back(mk(1, 0, 4'hE, 5'b00000, 2'b00, 0, 1, 0, 4'h0, 4'b0000, 1, 5'b00100, 0, 0));
      vq.push_back(mk(1, 0, 4'hE, 5'b00000, 2'b00, 1, 1, 0, 4'h0, 4'b0000, 1, 5'b10100, 0, 0));
      vq.push_back(mk(1, 0, 4'hE, 5'b00000, 2'b00, 0, 1, 0, 4'h0, 4'b0000, 1, 5'b00100, 0, 0));
      vq.push_back(mk(1, 0, 4'h1, 5'b00000, 2'b00, 1, 0, 0, 4'h0, 4'b0000, 0, 5'b00100, 0, 0));
      // stall holds flags, condition still evaluated
      vq.push_back(mk(1, 1, 4'hE, 5'b01000, 2'b11, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b00100, 0, 0));
      // 4: ITTE EQ with Z=1, stall mid-block
      vq.push_back(mk(1, 0, 4'hE, 5'b00000, 2'b11, 1, 0, 1, 4'h0, 4'b0110, 1, 5'b00100, 1, 0));
      vq.push_back(mk(1, 0, 4'hE, 5'b00000, 2'b00, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b00100, 1, 0));
      vq.push_back(mk(1, 1, 4'hE, 5'b00000, 2'b00, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b00100, 1, 0));
      vq.push_back(mk(1, 0, 4'h1, 5'b00000, 2'b00, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b00100, 1, 0));
      vq.push_back(mk(1, 0, 4'hE, 5'b00000, 2'b11, 0, 0, 0, 4'h0, 4'b0000, 0, 5'b00100, 0, 0));
      vq.push_back(mk(1, 0, 4'hE, 5'b00000, 2'b00, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b00100, 0, 0));
      // 5: faults
      vq.push_back(mk(1, 0, 4'hE, 5'b00000, 2'b00, 0, 0, 1, 4'h0, 4'b0000, 1, 5'b00100, 0, 1));
      vq.push_back(mk(0, 0, 4'hE, 5'b00000, 2'b00, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b00100, 0, 0));
      vq.push_back(mk(1, 0, 4'hE, 5'b00000, 2'b00, 0, 0, 1, 4'h1, 4'b0100, 1, 5'b00100, 1, 0));
      vq.push_back(mk(1, 0, 4'hE, 5'b00000, 2'b00, 0, 0, 1, 4'h0, 4'b0110, 0, 5'b00100, 1, 1));
      vq.push_back(mk(1, 0, 4'hE, 5'b00000, 2'b00, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b00100, 0, 0));
      vq.push_back(mk(1, 1, 4'hE, 5'b00000, 2'b00, 0, 0, 1, 4'h0, 4'b0000, 1, 5'b00100, 0, 0));

      idle_inputs();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset Flags", {3'b0, cu.Flags}, 8'h00);
      check("reset InIT", {7'b0, cu.InIT}, 8'h00);
      check("reset ITFault", {7'b0, cu.ITFault}, 8'h00);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         drive(vq[i]);
         #1;
         check($sformatf("v%0d CondEx", i), {7'b0, cu.CondEx}, {7'b0, vq[i].e_cx});
         @(posedge clk);
         #1;
         check($sformatf("v%0d Flags", i), {3'b0, cu.Flags}, {3'b0, vq[i].e_flags});
         check($sformatf("v%0d InIT", i), {7'b0, cu.InIT}, {7'b0, vq[i].e_init});
         check($sformatf("v%0d ITFault", i), {7'b0, cu.ITFault}, {7'b0, vq[i].e_fault});
      end

      // 6: asynchronous reset between edges inside an IT block
      @(negedge clk);
      drive(mk(1, 0, 4'hE, 5'b00000, 2'b00, 0, 0, 1, 4'h0, 4'b0110, 1, 5'b0, 0, 0));
      @(posedge clk);
      #1;
      check("midreset pre InIT", {7'b0, cu.InIT}, 8'h01);
      check("midreset pre Flags", {3'b0, cu.Flags}, 8'h04);
      @(negedge clk);
      idle_inputs();
      #2;
      reset = 1'b0;
      #1;
      check("midreset InIT", {7'b0, cu.InIT}, 8'h00);
      check("midreset Flags", {3'b0, cu.Flags}, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      drive(mk(1, 0, 4'hE, 5'b00100, 2'b11, 0, 0, 0, 4'h0, 4'b0000, 1, 5'b0, 0, 0));
      #1;
      check("post reset CondEx", {7'b0, cu.CondEx}, 8'h01);
      @(posedge clk);
      #1;
      check("post reset Flags", {3'b0, cu.Flags}, 8'h04);
      check("post reset InIT", {7'b0, cu.InIT}, 8'h00);
      @(negedge clk);
      idle_inputs();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
